// File: rtl/phy_pkg.sv
// Shared PHY transmit constants: K characters, idle symbol and the
// ordered-set scheduler state encoding.
package phy_pkg;

    localparam logic [7:0] COM_K  = 8'hBC;
    localparam logic [7:0] SKP_K  = 8'h1C;
    localparam logic [7:0] IDLE_D = 8'h00;

    typedef enum logic [1:0] {
        ST_DATA,
        ST_COM,
        ST_SKP
    } skp_state_e;

    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/skp_interval_cnt.sv
// SKP interval counter with the pending and late-insertion flags.
// Optional macro SKP_FORCE_EN adds force_skp to set pending on demand.
module skp_interval_cnt
    import phy_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic clk,
    input  logic rst,
    input  logic load_com,
`ifdef SKP_FORCE_EN
    input  logic force_skp,
`endif
    output logic pending,
    output logic skp_late
);

    localparam int CW = cnt_w(SKP_INTERVAL);
    localparam logic [CW-1:0] LAST = CW'(SKP_INTERVAL - 1);
    localparam logic [CW-1:0] NEAR = CW'(SKP_INTERVAL - 2);

    logic [CW-1:0] cnt;
    logic          expire;

    // Expiry is the edge on which the counter reaches its last value, so
    // pending rises together with it and a COM can follow on the next edge.
    assign expire = (cnt == NEAR) && !load_com;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            pending  <= 1'b0;
            skp_late <= 1'b0;
        end else begin
            skp_late <= expire && pending;
            if (load_com) begin
                cnt     <= '0;
                pending <= 1'b0;
            end else begin
                // Wrapping keeps counting intervals while a set is held off,
                // so a second missed interval is seen and flagged as late.
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
`ifdef SKP_FORCE_EN
                if (expire || force_skp)
                    pending <= 1'b1;
`else
                if (expire)
                    pending <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: rtl/skp_os_scheduler.sv
// Inserts COM + SKP ordered sets into the 8b/10b transmit stream.
// Optional macro SKP_FORCE_EN adds the force_skp input.
module skp_os_scheduler
    import phy_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic [7:0] data_in,
    input  logic       data_k_in,
    input  logic       pkt_busy,
`ifdef SKP_FORCE_EN
    input  logic       force_skp,
`endif
    output logic       data_ready,
    output logic [7:0] enc_datain,
    output logic       enc_D_K_IN,
    output logic       skp_active,
    output logic       skp_late
);

    localparam int IW = cnt_w(SKP_COUNT);
    localparam logic [IW-1:0] IDX_LAST = IW'(SKP_COUNT - 1);

    skp_state_e    state;
    logic [IW-1:0] idx;
    logic          pending;
    logic          load_com;

    assign load_com   = (state == ST_DATA) && pending && !pkt_busy;
    assign data_ready = (state == ST_DATA) && !(pending && !pkt_busy);

    skp_interval_cnt #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load_com (load_com),
`ifdef SKP_FORCE_EN
        .force_skp(force_skp),
`endif
        .pending  (pending),
        .skp_late (skp_late)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_DATA;
            idx        <= '0;
            enc_datain <= IDLE_D;
            enc_D_K_IN <= 1'b0;
            skp_active <= 1'b0;
        end else begin
            unique case (state)
                ST_DATA: begin
                    if (load_com) begin
                        enc_datain <= COM_K;
                        enc_D_K_IN <= 1'b1;
                        skp_active <= 1'b1;
                        state      <= ST_COM;
                    end else if (data_valid) begin
                        enc_datain <= data_in;
                        enc_D_K_IN <= data_k_in;
                        skp_active <= 1'b0;
                    end else begin
                        enc_datain <= IDLE_D;
                        enc_D_K_IN <= 1'b0;
                        skp_active <= 1'b0;
                    end
                end
                // The COM state issues SKP 0; SKP state issues 1..SKP_COUNT-1.
                ST_COM: begin
                    enc_datain <= SKP_K;
                    enc_D_K_IN <= 1'b1;
                    skp_active <= 1'b1;
                    if (SKP_COUNT == 1) begin
                        state <= ST_DATA;
                    end else begin
                        state <= ST_SKP;
                        idx   <= IW'(1);
                    end
                end
                ST_SKP: begin
                    enc_datain <= SKP_K;
                    enc_D_K_IN <= 1'b1;
                    skp_active <= 1'b1;
                    if (idx == IDX_LAST) begin
                        state <= ST_DATA;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_DATA;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule
